// File: rtl/frame_line_fetcher_pkg.sv
// Shared definitions for the frame line fetcher: FSM encoding, address layout
// and transfer constants that must agree with the DDR2 manager.
package frame_line_fetcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int         ADDR_W            = 25;
  localparam int         BANK_W            = 2;
  localparam logic [9:0] DEF_XFR_LEN       = 10'h010;
  localparam int         DEF_WORDS_PER_XFR = 2;

  // Advance a burst address while leaving the bank field untouched.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [ADDR_W-1:0] step);
    logic [ADDR_W-1:0] sum;
    sum = addr + step;
    return {sum[ADDR_W-1:BANK_W], addr[BANK_W-1:0]};
  endfunction

endpackage

// File: rtl/fl_sync_fifo.sv
// Single-clock FIFO with registered read data, word-count output and a
// synchronous flush; pointers carry an extra wrap bit.
module fl_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  // A full FIFO has exactly DEPTH words, i.e. only the top level bit set.
  assign do_push = push && !flush && !level[AW];
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/frame_line_fetcher.sv
// Walks a DDR2 frame with burst reads and buffers the returned words for the
// pixel pipeline, requesting a new burst whenever a whole one will fit.
module frame_line_fetcher
  import frame_line_fetcher_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 64,
  parameter logic [9:0]  XFR_LEN        = DEF_XFR_LEN,
  parameter int          WORDS_PER_XFR  = DEF_WORDS_PER_XFR,
  parameter logic [15:0] REQS_PER_FRAME = 16'd600
) (
  input  logic                            clk0,
  input  logic                            rst0_n,
  input  logic [ADDR_W-1:0]               frame_base,
  input  logic                            frame_start,
  input  logic                            enable,
  output logic                            rd_mem_req,
  output logic [ADDR_W-1:0]               rd_mem_addr,
  output logic [9:0]                      rd_xfr_len,
  input  logic                            rd_mem_grant,
  input  logic [31:0]                     rd_data,
  input  logic                            rd_data_valid,
  input  logic                            pix_rd_en,
  output logic [31:0]                     pix_data,
  output logic                            pix_empty,
  output logic                            frame_done,
  output logic                            underflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int                    BURST_WORDS = int'(XFR_LEN) * WORDS_PER_XFR;
  localparam int                    LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int                    WC_W        = $clog2(BURST_WORDS);
  localparam logic [ADDR_W-1:0]     ADDR_STEP   = {15'd0, XFR_LEN} << 3;
  localparam logic [LVL_W-1:0]      MAX_LEVEL   = LVL_W'(FIFO_DEPTH - BURST_WORDS);
  localparam logic [WC_W-1:0]       LAST_WORD   = WC_W'(BURST_WORDS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] pend_base_reg, pend_base_next;
  logic              req_reg, req_next;
  logic              pending_reg, pending_next;
  logic              underflow_reg, underflow_next;
  logic [15:0]       req_cnt_reg, req_cnt_next;
  logic [WC_W-1:0]   word_cnt_reg, word_cnt_next;
  logic              fifo_push;
  logic              fifo_flush;
  logic              restart;

  fl_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk0),
    .rst_n (rst0_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (rd_data),
    .pop   (pix_rd_en),
    .dout  (pix_data),
    .empty (pix_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      pend_base_reg <= '0;
      req_reg       <= 1'b0;
      pending_reg   <= 1'b0;
      underflow_reg <= 1'b0;
      req_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      pend_base_reg <= pend_base_next;
      req_reg       <= req_next;
      pending_reg   <= pending_next;
      underflow_reg <= underflow_next;
      req_cnt_reg   <= req_cnt_next;
      word_cnt_reg  <= word_cnt_next;
    end
  end

  // A restart requested mid-burst takes effect once the burst has drained.
  assign restart = pending_reg || frame_start;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    pend_base_next = pend_base_reg;
    req_next       = req_reg;
    pending_next   = pending_reg;
    req_cnt_next   = req_cnt_reg;
    word_cnt_next  = word_cnt_reg;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    underflow_next = (frame_start ? 1'b0 : underflow_reg) | (pix_rd_en & pix_empty);

    if (frame_start && state_reg != ST_DATA) begin
      addr_next    = frame_base;
      req_cnt_next = '0;
      req_next     = 1'b0;
      fifo_flush   = 1'b1;
      state_next   = ST_CHECK;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_IDLE;
        ST_CHECK: begin
          if (req_cnt_reg == REQS_PER_FRAME) begin
            state_next = ST_DONE;
          end else if (enable && fifo_level <= MAX_LEVEL) begin
            req_next   = 1'b1;
            state_next = ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_mem_grant) begin
            req_next      = 1'b0;
            word_cnt_next = '0;
            state_next    = ST_DATA;
          end
        end
        ST_DATA: begin
          if (frame_start) begin
            pending_next   = 1'b1;
            pend_base_next = frame_base;
          end
          if (rd_data_valid) begin
            fifo_push     = !restart;
            word_cnt_next = word_cnt_reg + 1'b1;
            if (word_cnt_reg == LAST_WORD) begin
              if (restart) begin
                fifo_flush   = 1'b1;
                addr_next    = frame_start ? frame_base : pend_base_reg;
                req_cnt_next = '0;
                pending_next = 1'b0;
              end else begin
                addr_next    = next_addr(addr_reg, ADDR_STEP);
                req_cnt_next = req_cnt_reg + 16'd1;
              end
              state_next = ST_CHECK;
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign rd_mem_req  = req_reg;
  assign rd_mem_addr = addr_reg;
  assign rd_xfr_len  = XFR_LEN;
  assign frame_done  = (state_reg == ST_DONE);
  assign underflow   = underflow_reg;

`ifndef SYNTHESIS
  // The manager must only return data while a granted burst is outstanding.
  a_valid_in_data: assert property (@(posedge clk0) disable iff (!rst0_n)
    rd_data_valid |-> state_reg == ST_DATA);
`endif

endmodule

// File: tb/tb_frame_line_fetcher.sv
// Directed bench for frame_line_fetcher: reset, underflow, a three-burst frame
// with grant delay, back-pressure and gapped data, then a mid-burst restart.
module tb_frame_line_fetcher;

  logic        clk0          = 1'b0;
  logic        rst0_n        = 1'b0;
  logic [24:0] frame_base    = '0;
  logic        frame_start   = 1'b0;
  logic        enable        = 1'b1;
  logic        rd_mem_req;
  logic [24:0] rd_mem_addr;
  logic [9:0]  rd_xfr_len;
  logic        rd_mem_grant  = 1'b0;
  logic [31:0] rd_data       = '0;
  logic        rd_data_valid = 1'b0;
  logic        pix_rd_en     = 1'b0;
  logic [31:0] pix_data;
  logic        pix_empty;
  logic        frame_done;
  logic        underflow;
  logic [6:0]  fifo_level;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk0 = ~clk0;

  frame_line_fetcher #(
    .FIFO_DEPTH     (64),
    .XFR_LEN        (10'h010),
    .WORDS_PER_XFR  (2),
    .REQS_PER_FRAME (16'd3)
  ) dut (
    .clk0          (clk0),
    .rst0_n        (rst0_n),
    .frame_base    (frame_base),
    .frame_start   (frame_start),
    .enable        (enable),
    .rd_mem_req    (rd_mem_req),
    .rd_mem_addr   (rd_mem_addr),
    .rd_xfr_len    (rd_xfr_len),
    .rd_mem_grant  (rd_mem_grant),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .pix_rd_en     (pix_rd_en),
    .pix_data      (pix_data),
    .pix_empty     (pix_empty),
    .frame_done    (frame_done),
    .underflow     (underflow),
    .fifo_level    (fifo_level)
  );

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rd_mem_req) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = rd_mem_req;
  endtask

  task automatic grant_pulse();
    rd_mem_grant = 1'b1;
    tick();
    rd_mem_grant = 1'b0;
  endtask

  task automatic pulse_start(input logic [24:0] base);
    frame_base  = base;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst0_n = 1'b1;
    tick();
    checks++; if (rd_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", rd_mem_req); end
    checks++; if (rd_mem_addr !== 25'h0) begin errors++; $display("FAIL reset_addr got %0h want 0", rd_mem_addr); end
    checks++; if (pix_data !== 32'h0) begin errors++; $display("FAIL reset_pix_data got %0h want 0", pix_data); end
    checks++; if (pix_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", pix_empty); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", frame_done); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %0b want 0", underflow); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (rd_xfr_len !== 10'h010) begin errors++; $display("FAIL xfr_len got %0h want 10", rd_xfr_len); end
  endtask

  task automatic test_underflow();
    pix_rd_en = 1'b1;
    tick();
    pix_rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %0b want 1", underflow); end
    checks++; if (pix_empty !== 1'b1) begin errors++; $display("FAIL uf_empty got %0b want 1", pix_empty); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL uf_level got %0d want 0", fifo_level); end
    checks++; if (pix_data !== 32'h0) begin errors++; $display("FAIL uf_data got %0h want 0", pix_data); end
    repeat (3) tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %0b want 1", underflow); end
  endtask

  task automatic test_frame();
    bit          ok;
    bit          stable;
    bit          quiet;
    int          done_cnt;
    int          sent;
    logic [31:0] exp;
    pulse_start(25'h0000100);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %0b want 0", underflow); end
    wait_req(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL req1_timeout got 0 want 1"); end
    checks++; if (rd_mem_addr !== 25'h100) begin errors++; $display("FAIL req1_addr got %0h want 100", rd_mem_addr); end
    // Grant withheld for 50 cycles: request and address must hold.
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rd_mem_req !== 1'b1 || rd_mem_addr !== 25'h100) stable = 1'b0;
      tick();
    end
    checks++; if (!stable) begin errors++; $display("FAIL req_hold got unstable want stable"); end
    grant_pulse();
    checks++; if (rd_mem_req !== 1'b0) begin errors++; $display("FAIL req_drop got %0b want 0", rd_mem_req); end
    for (int i = 0; i < 32; i++) begin
      rd_data_valid = 1'b1; rd_data = 32'hA000_0000 + i; exp_q.push_back(rd_data); tick();
    end
    rd_data_valid = 1'b0;
    checks++; if (fifo_level !== 7'd32) begin errors++; $display("FAIL b1_level got %0d want 32", fifo_level); end
    wait_req(10, ok);
    checks++; if (!ok || rd_mem_addr !== 25'h180) begin errors++; $display("FAIL req2_addr got %0h want 180", rd_mem_addr); end
    grant_pulse();
    for (int i = 0; i < 32; i++) begin
      rd_data_valid = 1'b1; rd_data = 32'hA100_0000 + i; exp_q.push_back(rd_data); tick();
    end
    rd_data_valid = 1'b0;
    checks++; if (fifo_level !== 7'd64) begin errors++; $display("FAIL b2_level got %0d want 64", fifo_level); end
    // Full FIFO: third request must wait until a whole burst fits.
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (rd_mem_req !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL bp_full got req want none"); end
    for (int i = 0; i < 31; i++) begin
      pix_rd_en = 1'b1; tick(); exp = exp_q.pop_front();
      checks++; if (pix_data !== exp) begin errors++; $display("FAIL pop_data got %0h want %0h", pix_data, exp); end
    end
    pix_rd_en = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (rd_mem_req !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL bp_33 got req want none"); end
    pix_rd_en = 1'b1; tick(); pix_rd_en = 1'b0; exp = exp_q.pop_front();
    checks++; if (pix_data !== exp) begin errors++; $display("FAIL pop_data got %0h want %0h", pix_data, exp); end
    checks++; if (fifo_level !== 7'd32) begin errors++; $display("FAIL bp_level got %0d want 32", fifo_level); end
    checks++; if (rd_mem_req !== 1'b0) begin errors++; $display("FAIL bp_early got %0b want 0", rd_mem_req); end
    tick();
    checks++; if (rd_mem_req !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", rd_mem_req); end
    checks++; if (rd_mem_addr !== 25'h200) begin errors++; $display("FAIL req3_addr got %0h want 200", rd_mem_addr); end
    grant_pulse();
    // Gapped data (1 on, 2 off) while the consumer drains every cycle.
    sent = 0;
    done_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      rd_data_valid = (sent < 32) && (c % 3 == 0);
      rd_data       = 32'hA200_0000 + sent;
      pix_rd_en     = (exp_q.size() > 0);
      tick();
      if (frame_done === 1'b1) done_cnt++;
      if (pix_rd_en) begin
        exp = exp_q.pop_front();
        checks++; if (pix_data !== exp) begin errors++; $display("FAIL gap_data got %0h want %0h", pix_data, exp); end
      end
      if (rd_data_valid) begin exp_q.push_back(rd_data); sent++; end
      checks++; if (int'(fifo_level) != exp_q.size()) begin errors++; $display("FAIL gap_level got %0d want %0d", fifo_level, exp_q.size()); end
      checks++; if (pix_empty !== (exp_q.size() == 0)) begin errors++; $display("FAIL gap_empty got %0b want %0b", pix_empty, exp_q.size() == 0); end
    end
    rd_data_valid = 1'b0;
    pix_rd_en     = 1'b0;
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", done_cnt); end
    checks++; if (rd_mem_req !== 1'b0) begin errors++; $display("FAIL post_frame_req got %0b want 0", rd_mem_req); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL frame_underflow got %0b want 0", underflow); end
  endtask

  task automatic test_restart();
    bit ok;
    bit held;
    pulse_start(25'h0004000);
    wait_req(10, ok);
    checks++; if (!ok || rd_mem_addr !== 25'h4000) begin errors++; $display("FAIL rs_addr1 got %0h want 4000", rd_mem_addr); end
    grant_pulse();
    for (int i = 0; i < 10; i++) begin
      rd_data_valid = 1'b1; rd_data = 32'hB000_0000 + i; tick();
    end
    rd_data_valid = 1'b0;
    checks++; if (fifo_level !== 7'd10) begin errors++; $display("FAIL rs_level10 got %0d want 10", fifo_level); end
    pulse_start(25'h0008000);
    held = 1'b1;
    for (int i = 0; i < 22; i++) begin
      rd_data_valid = 1'b1; rd_data = 32'hC000_0000 + i; tick();
      if (i < 21 && (fifo_level !== 7'd10 || rd_mem_req !== 1'b0)) held = 1'b0;
    end
    rd_data_valid = 1'b0;
    checks++; if (!held) begin errors++; $display("FAIL rs_discard got pushes want none"); end
    checks++; if (fifo_level !== 7'd0 || pix_empty !== 1'b1) begin errors++; $display("FAIL rs_flush got level %0d want 0", fifo_level); end
    wait_req(10, ok);
    checks++; if (!ok || rd_mem_addr !== 25'h8000) begin errors++; $display("FAIL rs_addr2 got %0h want 8000", rd_mem_addr); end
    grant_pulse();
    for (int i = 0; i < 32; i++) begin
      rd_data_valid = 1'b1; rd_data = 32'hD000_0000 + i; tick();
    end
    rd_data_valid = 1'b0;
    pix_rd_en = 1'b1; tick(); pix_rd_en = 1'b0;
    checks++; if (pix_data !== 32'hD000_0000) begin errors++; $display("FAIL rs_first got %0h want d0000000", pix_data); end
    checks++; if (fifo_level !== 7'd31) begin errors++; $display("FAIL rs_level got %0d want 31", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_frame();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
